// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Runtime-reprogrammable raster timing generator. A pixel/line counter pair
// walks the raster one position per enabled clock; every visible output is a
// register computed from the *next* position, so hsync/vsync/display_on/
// hblank/vblank always describe the hpos/vpos shown in the same cycle.
// A new timing can be offered at any time but is only swapped in on the edge
// where the counters wrap to (0,0), so no frame ever mixes two timings.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   ce                    pixel enable; counters and levels advance only when 1
//   cfg_valid/cfg_ready   config handshake (see below)
//   cfg_h_* / cfg_v_*     offered horizontal / vertical timing
//   cfg_err               one-cycle pulse: offered config was rejected
//   hpos, vpos            current pixel column / line
//   hsync, vsync          polarity-applied sync levels
//   display_on, hblank, vblank  visibility flags for the current position
//   line_start            one-cycle strobe: hpos just became 0
//   frame_start           one-cycle strobe: (hpos,vpos) just became (0,0)
//   frame_count           frames started since reset, wrapping
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int HW         = 9,
    parameter int VW         = 9,
    parameter int FCW        = 8,
    parameter int H_ACTIVE_D = 256,
    parameter int H_SS_D     = 263,
    parameter int H_SE_D     = 285,
    parameter int H_TOTAL_D  = 300,
    parameter int V_ACTIVE_D = 256,
    parameter int V_SS_D     = 270,
    parameter int V_SE_D     = 272,
    parameter int V_TOTAL_D  = 278,
    parameter bit HSYNC_POL  = 1'b1,
    parameter bit VSYNC_POL  = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ce,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [HW-1:0]  cfg_h_active,
    input  logic [HW-1:0]  cfg_h_ss,
    input  logic [HW-1:0]  cfg_h_se,
    input  logic [HW-1:0]  cfg_h_total,
    input  logic [VW-1:0]  cfg_v_active,
    input  logic [VW-1:0]  cfg_v_ss,
    input  logic [VW-1:0]  cfg_v_se,
    input  logic [VW-1:0]  cfg_v_total,
    output logic           cfg_err,
    output logic [HW-1:0]  hpos,
    output logic [VW-1:0]  vpos,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic           hblank,
    output logic           vblank,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count
);

    typedef struct packed {
        logic [HW-1:0] h_active;
        logic [HW-1:0] h_ss;
        logic [HW-1:0] h_se;
        logic [HW-1:0] h_total;
        logic [VW-1:0] v_active;
        logic [VW-1:0] v_ss;
        logic [VW-1:0] v_se;
        logic [VW-1:0] v_total;
    } timing_t;

    localparam timing_t TIMING_D = '{
        h_active: HW'(H_ACTIVE_D), h_ss: HW'(H_SS_D),
        h_se:     HW'(H_SE_D),     h_total: HW'(H_TOTAL_D),
        v_active: VW'(V_ACTIVE_D), v_ss: VW'(V_SS_D),
        v_se:     VW'(V_SE_D),     v_total: VW'(V_TOTAL_D)
    };

    timing_t       act_t;     // timing the counters currently run with
    timing_t       pend_t;    // accepted timing waiting for the next (0,0)
    logic          pend;      // pend_t holds a config not yet applied
    timing_t       cfg_t;
    timing_t       nxt_t;
    logic          h_last;
    logic          v_last;
    logic          frame_wrap;
    logic          cfg_legal;
    logic          cfg_accept;
    logic [HW-1:0] nxt_h;
    logic [VW-1:0] nxt_v;

    assign cfg_t = {cfg_h_active, cfg_h_ss, cfg_h_se, cfg_h_total,
                    cfg_v_active, cfg_v_ss, cfg_v_se, cfg_v_total};

    // Handshake: a transfer happens on a clk edge where cfg_valid && cfg_ready.
    // A legal transfer is latched as pending and drops cfg_ready from the next
    // cycle until the cycle after it is applied at (0,0); an illegal transfer
    // is dropped and flagged on cfg_err for one cycle. cfg_valid while
    // cfg_ready is low has no effect.
    always_comb begin
        cfg_legal  = (cfg_h_active != '0) && (cfg_h_active <= cfg_h_ss) &&
                     (cfg_h_ss <= cfg_h_se) && (cfg_h_se < cfg_h_total) &&
                     (cfg_v_active != '0) && (cfg_v_active <= cfg_v_ss) &&
                     (cfg_v_ss <= cfg_v_se) && (cfg_v_se < cfg_v_total);
        cfg_accept = cfg_valid && cfg_ready && cfg_legal;

        // Wrap decisions always use the running timing, so a shrunk total
        // never cuts the current frame short.
        h_last     = (hpos == act_t.h_total - HW'(1));
        v_last     = (vpos == act_t.v_total - VW'(1));
        frame_wrap = h_last && v_last;

        nxt_h = h_last ? '0 : hpos + HW'(1);
        if (!h_last)
            nxt_v = vpos;
        else if (v_last)
            nxt_v = '0;
        else
            nxt_v = vpos + VW'(1);

        // The levels registered at the (0,0) edge already use the new timing.
        nxt_t = (frame_wrap && pend) ? pend_t : act_t;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_t       <= TIMING_D;
            pend_t      <= TIMING_D;
            pend        <= 1'b0;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
            hpos        <= HW'(H_TOTAL_D - 1);
            vpos        <= VW'(V_TOTAL_D - 1);
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            display_on  <= 1'b0;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            cfg_err     <= cfg_valid && cfg_ready && !cfg_legal;
            // Uses the pre-edge pend, so ready stays low for the (0,0) cycle
            // in which a pending config is applied.
            cfg_ready   <= !pend && !cfg_accept;

            if (cfg_accept) begin
                pend_t <= cfg_t;
                pend   <= 1'b1;
            end

            if (ce) begin
                hpos        <= nxt_h;
                vpos        <= nxt_v;
                act_t       <= nxt_t;
                hsync       <= ((nxt_h >= nxt_t.h_ss) && (nxt_h <= nxt_t.h_se)) ?
                               HSYNC_POL : ~HSYNC_POL;
                vsync       <= ((nxt_v >= nxt_t.v_ss) && (nxt_v <= nxt_t.v_se)) ?
                               VSYNC_POL : ~VSYNC_POL;
                display_on  <= (nxt_h < nxt_t.h_active) && (nxt_v < nxt_t.v_active);
                hblank      <= (nxt_h >= nxt_t.h_active);
                vblank      <= (nxt_v >= nxt_t.v_active);
                line_start  <= h_last;
                frame_start <= frame_wrap;
                if (frame_wrap)
                    frame_count <= frame_count + FCW'(1);
                // pend can only be set while cfg_ready=1, i.e. never in the
                // same cycle it is cleared here.
                if (frame_wrap && pend)
                    pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
module tb_video_timing_gen;

    localparam int HW  = 9;
    localparam int VW  = 9;
    localparam int FCW = 8;

    typedef struct {
        int ha, hss, hse, ht, va, vss, vse, vt;
    } tim_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n, ce, cfg_valid, cfg_ready, cfg_err;
    logic [1:0] hsync, vsync, display_on, hblank, vblank, line_start, frame_start;
    logic [1:0][HW-1:0]  cfg_h_active, cfg_h_ss, cfg_h_se, cfg_h_total, hpos;
    logic [1:0][VW-1:0]  cfg_v_active, cfg_v_ss, cfg_v_se, cfg_v_total, vpos;
    logic [1:0][FCW-1:0] frame_count;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit ce_on[2];
    int ce_div[2];

    // dut0: default 300x278 raster, active-high syncs
    video_timing_gen u_dut0 (
        .clk(clk), .reset(rst_n[0]), .ce(ce[0]),
        .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]),
        .cfg_h_active(cfg_h_active[0]), .cfg_h_ss(cfg_h_ss[0]),
        .cfg_h_se(cfg_h_se[0]), .cfg_h_total(cfg_h_total[0]),
        .cfg_v_active(cfg_v_active[0]), .cfg_v_ss(cfg_v_ss[0]),
        .cfg_v_se(cfg_v_se[0]), .cfg_v_total(cfg_v_total[0]),
        .cfg_err(cfg_err[0]), .hpos(hpos[0]), .vpos(vpos[0]),
        .hsync(hsync[0]), .vsync(vsync[0]), .display_on(display_on[0]),
        .hblank(hblank[0]), .vblank(vblank[0]), .line_start(line_start[0]),
        .frame_start(frame_start[0]), .frame_count(frame_count[0])
    );

    // dut1: small 24x14 raster, active-low syncs
    video_timing_gen #(
        .H_ACTIVE_D(16), .H_SS_D(18), .H_SE_D(20), .H_TOTAL_D(24),
        .V_ACTIVE_D(10), .V_SS_D(11), .V_SE_D(12), .V_TOTAL_D(14),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .ce(ce[1]),
        .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]),
        .cfg_h_active(cfg_h_active[1]), .cfg_h_ss(cfg_h_ss[1]),
        .cfg_h_se(cfg_h_se[1]), .cfg_h_total(cfg_h_total[1]),
        .cfg_v_active(cfg_v_active[1]), .cfg_v_ss(cfg_v_ss[1]),
        .cfg_v_se(cfg_v_se[1]), .cfg_v_total(cfg_v_total[1]),
        .cfg_err(cfg_err[1]), .hpos(hpos[1]), .vpos(vpos[1]),
        .hsync(hsync[1]), .vsync(vsync[1]), .display_on(display_on[1]),
        .hblank(hblank[1]), .vblank(vblank[1]), .line_start(line_start[1]),
        .frame_start(frame_start[1]), .frame_count(frame_count[1])
    );

    // ---------------- behavioural model ----------------
    // Position is kept as a linear pixel index within the frame; hpos/vpos
    // are derived from it by division against the frame's timing.
    tim_t m_t[2];
    tim_t m_p[2];
    int   m_n[2];
    int   m_fc[2];
    bit   m_pend[2], m_rdy[2], m_rel[2], m_err[2], m_ls[2], m_fs[2];

    function automatic tim_t mk(int ha, int hss, int hse, int ht,
                                int va, int vss, int vse, int vt);
        tim_t t;
        t.ha = ha; t.hss = hss; t.hse = hse; t.ht = ht;
        t.va = va; t.vss = vss; t.vse = vse; t.vt = vt;
        return t;
    endfunction

    function automatic tim_t def_tim(int k);
        if (k == 0) return mk(256, 263, 285, 300, 256, 270, 272, 278);
        return mk(16, 18, 20, 24, 10, 11, 12, 14);
    endfunction

    function automatic bit legal(tim_t t);
        return t.ha > 0 && t.ha <= t.hss && t.hss <= t.hse && t.hse < t.ht &&
               t.va > 0 && t.va <= t.vss && t.vss <= t.vse && t.vse < t.vt;
    endfunction

    function automatic tim_t cfg_in(int k);
        return mk(int'(cfg_h_active[k]), int'(cfg_h_ss[k]), int'(cfg_h_se[k]),
                  int'(cfg_h_total[k]), int'(cfg_v_active[k]), int'(cfg_v_ss[k]),
                  int'(cfg_v_se[k]), int'(cfg_v_total[k]));
    endfunction

    task automatic model_reset(int k);
        m_t[k] = def_tim(k);
        m_n[k] = m_t[k].ht * m_t[k].vt - 1;
        m_fc[k] = 0; m_pend[k] = 0; m_rdy[k] = 1; m_rel[k] = 0;
        m_err[k] = 0; m_ls[k] = 0; m_fs[k] = 0;
    endtask

    task automatic model_step(int k);
        bit old_rdy;
        tim_t c;
        old_rdy = m_rdy[k];
        m_err[k] = 0; m_ls[k] = 0; m_fs[k] = 0;
        if (m_rel[k]) begin m_rdy[k] = 1; m_rel[k] = 0; end
        if (ce[k]) begin
            m_n[k]++;
            if (m_n[k] == m_t[k].ht * m_t[k].vt) begin
                m_n[k] = 0; m_fs[k] = 1; m_fc[k] = (m_fc[k] + 1) % 256;
                if (m_pend[k]) begin m_t[k] = m_p[k]; m_pend[k] = 0; m_rel[k] = 1; end
            end
            if (m_n[k] % m_t[k].ht == 0) m_ls[k] = 1;
        end
        if (cfg_valid[k] && old_rdy) begin
            c = cfg_in(k);
            if (legal(c)) begin m_p[k] = c; m_pend[k] = 1; m_rdy[k] = 0; end
            else m_err[k] = 1;
        end
    endtask

    // Resets are only ever changed while clk is low, so clk==1 marks a clock edge.
    always @(posedge clk or negedge rst_n[0] or negedge rst_n[1]) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) model_reset(k);
            else if (clk) model_step(k);
        end
    end

    function automatic logic [34:0] exp_vec(int k);
        int hp, vp; bit p, hs, vs; tim_t t;
        t = m_t[k];
        hp = m_n[k] % t.ht;
        vp = m_n[k] / t.ht;
        p = (k == 0);
        hs = (hp >= t.hss && hp <= t.hse) ? p : !p;
        vs = (vp >= t.vss && vp <= t.vse) ? p : !p;
        return {m_rdy[k], m_err[k], 9'(hp), 9'(vp), hs, vs,
                (hp < t.ha && vp < t.va), (hp >= t.ha), (vp >= t.va),
                m_ls[k], m_fs[k], 8'(m_fc[k])};
    endfunction

    function automatic logic [34:0] act_vec(int k);
        return {cfg_ready[k], cfg_err[k], hpos[k], vpos[k], hsync[k], vsync[k],
                display_on[k], hblank[k], vblank[k], line_start[k],
                frame_start[k], frame_count[k]};
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic chk(string name, int act, int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: compare both DUTs against the model, then set up ce.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (act_vec(k) !== exp_vec(k)) begin
                    tests_failed++;
                    $display("FAIL model_dut%0d cyc %0d: got %h, expected %h",
                             k, cyc, act_vec(k), exp_vec(k));
                end
            end
        end
        for (int k = 0; k < 2; k++)
            ce[k] = ce_on[k] && ((cyc % ce_div[k]) == 0);
    endtask

    task automatic wait_ls(int k, int limit, output int n);
        n = 0;
        do begin step(); n++; end while (!line_start[k] && n < limit);
        if (!line_start[k]) chk($sformatf("ls_timeout_dut%0d", k), 0, 1);
    endtask

    task automatic wait_fs(int k, int limit, output int n);
        n = 0;
        do begin step(); n++; end while (!frame_start[k] && n < limit);
        if (!frame_start[k]) chk($sformatf("fs_timeout_dut%0d", k), 0, 1);
    endtask

    task automatic wait_pos(int k, int h, int v, int limit);
        int n;
        n = 0;
        while (!(int'(hpos[k]) == h && int'(vpos[k]) == v) && n < limit) begin
            step(); n++;
        end
        if (!(int'(hpos[k]) == h && int'(vpos[k]) == v))
            chk($sformatf("pos_timeout_dut%0d", k), 0, 1);
    endtask

    task automatic offer(int k, tim_t t);
        cfg_h_active[k] = HW'(t.ha); cfg_h_ss[k] = HW'(t.hss);
        cfg_h_se[k] = HW'(t.hse);    cfg_h_total[k] = HW'(t.ht);
        cfg_v_active[k] = VW'(t.va); cfg_v_ss[k] = VW'(t.vss);
        cfg_v_se[k] = VW'(t.vse);    cfg_v_total[k] = VW'(t.vt);
        cfg_valid[k] = 1'b1;
        step();
        cfg_valid[k] = 1'b0;
    endtask

    // Whole-frame statistics with ce=1, from one frame_start to the next.
    task automatic frame_stats(int k, output int per, output int disp,
                               output int hmin, output int hmax,
                               output int vmin, output int vmax);
        int n;
        bit p;
        p = (k == 0);
        wait_fs(k, 5000, n);
        per = 0; disp = 0; hmin = 9999; hmax = -1; vmin = 9999; vmax = -1;
        do begin
            if (display_on[k]) disp++;
            if (hsync[k] == p) begin
                if (int'(hpos[k]) < hmin) hmin = int'(hpos[k]);
                if (int'(hpos[k]) > hmax) hmax = int'(hpos[k]);
            end
            if (vsync[k] == p) begin
                if (int'(vpos[k]) < vmin) vmin = int'(vpos[k]);
                if (int'(vpos[k]) > vmax) vmax = int'(vpos[k]);
            end
            step(); per++;
        end while (!frame_start[k] && per < 5000);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n, per, disp, hmin, hmax, vmin, vmax;
        tim_t t;

        rst_n = 2'b00; ce = 2'b00; cfg_valid = 2'b00;
        cfg_h_active = '0; cfg_h_ss = '0; cfg_h_se = '0; cfg_h_total = '0;
        cfg_v_active = '0; cfg_v_ss = '0; cfg_v_se = '0; cfg_v_total = '0;
        ce_on = '{0, 0}; ce_div = '{1, 1};
        repeat (3) @(negedge clk);
        chk_en = 1;
        step();

        // Reset values
        chk("rst_hpos0", int'(hpos[0]), 299);
        chk("rst_vpos0", int'(vpos[0]), 277);
        chk("rst_hsync0", int'(hsync[0]), 0);
        chk("rst_vsync0", int'(vsync[0]), 0);
        chk("rst_disp0", int'(display_on[0]), 0);
        chk("rst_hblank0", int'(hblank[0]), 1);
        chk("rst_vblank0", int'(vblank[0]), 1);
        chk("rst_fc0", int'(frame_count[0]), 0);
        chk("rst_ready0", int'(cfg_ready[0]), 1);
        chk("rst_hpos1", int'(hpos[1]), 23);
        chk("rst_hsync1_lowpol", int'(hsync[1]), 1);
        chk("rst_vsync1_lowpol", int'(vsync[1]), 1);

        // Release; first ce gives (0,0) with a frame strobe
        rst_n = 2'b11;
        ce_on = '{1, 1}; ce = 2'b11;
        step();
        chk("first_fs0", int'(frame_start[0]), 1);
        chk("first_fc0", int'(frame_count[0]), 1);
        chk("first_hpos0", int'(hpos[0]), 0);
        chk("first_vpos0", int'(vpos[0]), 0);
        chk("first_fs1", int'(frame_start[1]), 1);
        step();
        chk("fs0_width", int'(frame_start[0]), 0);

        // dut1 second frame 336 clocks after the first
        wait_fs(1, 1000, n);
        chk("dut1_frame_period", n + 1, 336);
        chk("dut1_fc_two", int'(frame_count[1]), 2);

        // dut0 default line: hsync window 263..285, period 300
        wait_ls(0, 400, n);
        hmin = 9999; hmax = -1;
        for (int i = 0; i < 300; i++) begin
            if (hsync[0]) begin
                if (int'(hpos[0]) < hmin) hmin = int'(hpos[0]);
                if (int'(hpos[0]) > hmax) hmax = int'(hpos[0]);
            end
            step();
        end
        chk("dut0_hs_min", hmin, 263);
        chk("dut0_hs_max", hmax, 285);
        chk("dut0_line_period", int'(line_start[0]), 1);
        step();
        chk("ls0_width", int'(line_start[0]), 0);

        // dut1 full frame with default small timing (active-low syncs)
        frame_stats(1, per, disp, hmin, hmax, vmin, vmax);
        chk("dut1_per", per, 336);
        chk("dut1_disp", disp, 160);
        chk("dut1_hs_min", hmin, 18);
        chk("dut1_hs_max", hmax, 20);
        chk("dut1_vs_min", vmin, 11);
        chk("dut1_vs_max", vmax, 12);

        // ce one clock in three: line period 72, strobe still one clock
        ce_div[1] = 3;
        wait_ls(1, 200, n);
        wait_ls(1, 200, n);
        chk("ce3_line_period", n, 72);
        step();
        chk("ce3_ls_width", int'(line_start[1]), 0);
        ce_div[1] = 1;

        // Mid-frame config load on dut1
        wait_pos(1, 0, 5, 1000);
        t = mk(10, 12, 14, 16, 6, 7, 8, 9);
        offer(1, t);
        chk("cfg_ready_low", int'(cfg_ready[1]), 0);
        wait_ls(1, 100, n);
        wait_ls(1, 100, n);
        chk("old_line_period", n, 24);
        wait_fs(1, 1000, n);
        chk("ready_low_at_00", int'(cfg_ready[1]), 0);
        step();
        chk("ready_back", int'(cfg_ready[1]), 1);
        wait_ls(1, 100, n);
        wait_ls(1, 100, n);
        chk("new_line_period", n, 16);
        frame_stats(1, per, disp, hmin, hmax, vmin, vmax);
        chk("new_per", per, 144);
        chk("new_disp", disp, 60);
        chk("new_hs_min", hmin, 12);
        chk("new_hs_max", hmax, 14);
        chk("new_vs_min", vmin, 7);
        chk("new_vs_max", vmax, 8);

        // Illegal config: h_ss below h_active
        t = mk(10, 9, 14, 16, 6, 7, 8, 9);
        offer(1, t);
        chk("illegal_err", int'(cfg_err[1]), 1);
        chk("illegal_ready", int'(cfg_ready[1]), 1);
        step();
        chk("illegal_err_width", int'(cfg_err[1]), 0);
        frame_stats(1, per, disp, hmin, hmax, vmin, vmax);
        chk("illegal_keeps_per", per, 144);

        // dut0: config pending, ignored second offer, then reset mid-frame
        wait_pos(0, 0, 20, 20000);
        t = mk(160, 168, 180, 200, 120, 122, 124, 130);
        offer(0, t);
        chk("dut0_pending_ready", int'(cfg_ready[0]), 0);
        t = mk(160, 150, 180, 200, 120, 122, 124, 130);
        offer(0, t);
        chk("not_ready_no_err", int'(cfg_err[0]), 0);
        chk("not_ready_still_low", int'(cfg_ready[0]), 0);
        wait_pos(0, 150, 40, 20000);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("midrst_hpos", int'(hpos[0]), 299);
        chk("midrst_vpos", int'(vpos[0]), 277);
        chk("midrst_fc", int'(frame_count[0]), 0);
        chk("midrst_ready", int'(cfg_ready[0]), 1);
        chk("midrst_hblank", int'(hblank[0]), 1);
        step();
        step();
        rst_n[0] = 1'b1;
        step();
        chk("post_rst_fs", int'(frame_start[0]), 1);
        chk("post_rst_fc", int'(frame_count[0]), 1);
        chk("post_rst_hpos", int'(hpos[0]), 0);
        wait_ls(0, 400, n);
        chk("post_rst_default_line", n, 300);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
